// File: rtl/de_port_arbiter_pkg.sv
// Shared drawing-engine definitions for the frame-store port arbiter.
// Holds the frame-store bus widths and the arbiter state encoding.
package de_port_arbiter_pkg;

  localparam int DE_ADDR_W  = 18;
  localparam int DE_DATA_W  = 32;
  localparam int DE_NBYTE_W = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/de_port_arbiter_rr_pick.sv
// Round-robin winner selection (purely combinational).
// Ports:
//   req_i   - NREQ-bit request vector
//   ptr_i   - slot index where the search starts
//   idx_o   - first requesting slot at or above ptr_i, wrapping modulo NREQ
//   valid_o - high when at least one slot is requesting
module de_port_arbiter_rr_pick
  import de_port_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // One extra bit so ptr+k never overflows before the modulo-NREQ wrap.
  localparam int PW = IDX_W + 1;

  logic [PW-1:0]    pos_s;
  logic [IDX_W-1:0] cand_s;

  // Scan NREQ candidate positions from ptr_i upward; the first hit wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    pos_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s = {1'b0, ptr_i} + PW'(k);
      // Explicit wrap keeps non-power-of-2 NREQ inside the valid range.
      if (pos_s >= PW'(NREQ)) begin
        pos_s = pos_s - PW'(NREQ);
      end else begin
        pos_s = pos_s;
      end
      cand_s = pos_s[IDX_W-1:0];
      if (!valid_o && req_i[cand_s]) begin
        valid_o = 1'b1;
        idx_o   = cand_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/de_port_arbiter.sv
// Frame-store drawing-port arbiter: shares one de_* port between NREQ
// drawing engines, round-robin, rotating after a release or MAX_BURST acks.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   rq_req/rq_ack       - per-slot request / acknowledge
//   rq_addr/nbyte/rnw/wdata - per-slot transfer fields, packed slot-major
//   rq_rdata            - frame-store read data, broadcast to every slot
//   de_*                - single frame-store port driven from the owner slot
//   grant               - registered one-hot owner, zero when idle
//   busy                - high while a slot holds the port
module de_port_arbiter
  import de_port_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            rq_req,
  output logic [NREQ-1:0]            rq_ack,
  input  logic [NREQ*DE_ADDR_W-1:0]  rq_addr,
  input  logic [NREQ*DE_NBYTE_W-1:0] rq_nbyte,
  input  logic [NREQ-1:0]            rq_rnw,
  input  logic [NREQ*DE_DATA_W-1:0]  rq_wdata,
  output logic [DE_DATA_W-1:0]       rq_rdata,
  output logic                       de_req,
  input  logic                       de_ack,
  output logic [DE_ADDR_W-1:0]       de_addr,
  output logic [DE_NBYTE_W-1:0]      de_nbyte,
  output logic                       de_rnw,
  output logic [DE_DATA_W-1:0]       de_w_data,
  input  logic [DE_DATA_W-1:0]       de_r_data,
  output logic [NREQ-1:0]            grant,
  output logic                       busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_valid_s;
  logic             owner_req_s;
  logic             last_beat_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NREQ - 1)) begin
      next_idx = '0;
    end else begin
      next_idx = idx + IDX_W'(1);
    end
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  de_port_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (rq_req),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  assign owner_req_s = rq_req[owner_q];
  assign last_beat_s = (beat_q == CNT_W'(MAX_BURST - 1));

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      grant_q  <= grant_d;
    end
  end

  // Next-state: pick a winner in IDLE, count beats and release in GRANT.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    grant_d  = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          state_d = ARB_GRANT;
          owner_d = pick_idx_s;
          beat_d  = '0;
          grant_d = onehot(pick_idx_s);
        end else begin
          grant_d = '0;
        end
      end
      ARB_GRANT: begin
        // A dropped request releases at once; otherwise release on the
        // final acknowledged beat so a busy slot cannot starve the others.
        if (!owner_req_s) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_idx(owner_q);
          grant_d  = '0;
        end else if (de_ack && last_beat_s) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_idx(owner_q);
          grant_d  = '0;
        end else if (de_ack) begin
          beat_d = beat_q + CNT_W'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Frame-store request and per-slot acknowledge follow the owner only in GRANT.
  always_comb begin
    de_req = 1'b0;
    rq_ack = '0;
    if (state_q == ARB_GRANT) begin
      de_req          = owner_req_s;
      rq_ack[owner_q] = de_ack;
    end else begin
      de_req = 1'b0;
      rq_ack = '0;
    end
  end

  assign de_addr   = rq_addr[int'(owner_q)*DE_ADDR_W +: DE_ADDR_W];
  assign de_nbyte  = rq_nbyte[int'(owner_q)*DE_NBYTE_W +: DE_NBYTE_W];
  assign de_rnw    = rq_rnw[owner_q];
  assign de_w_data = rq_wdata[int'(owner_q)*DE_DATA_W +: DE_DATA_W];
  assign rq_rdata  = de_r_data;
  assign grant     = grant_q;
  assign busy      = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_de_port_arbiter.sv
// Directed bench for de_port_arbiter with a grant/ack scoreboard.
module tb_de_port_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   rq_req;
  logic [3:0]   rq_ack;
  logic [71:0]  rq_addr;
  logic [15:0]  rq_nbyte;
  logic [3:0]   rq_rnw;
  logic [127:0] rq_wdata;
  logic [31:0]  rq_rdata;
  logic         de_req;
  logic         de_ack;
  logic [17:0]  de_addr;
  logic [3:0]   de_nbyte;
  logic         de_rnw;
  logic [31:0]  de_w_data;
  logic [31:0]  de_r_data;
  logic [3:0]   grant;
  logic         busy;

  logic         ack_en;
  logic         ack_force;

  logic [17:0]  addr_tab  [4];
  logic [3:0]   nbyte_tab [4];
  logic         rnw_tab   [4];
  logic [31:0]  wdata_tab [4];

  logic [3:0]   exp_grant_q [$];
  int           exp_ack_q   [$];
  logic [3:0]   prev_grant;

  int total;
  int bad;

  // Frame store model: acks only while requested, unless forced for the idle check.
  assign de_ack = (de_req & ack_en) | ack_force;

  de_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .rq_req    (rq_req),
    .rq_ack    (rq_ack),
    .rq_addr   (rq_addr),
    .rq_nbyte  (rq_nbyte),
    .rq_rnw    (rq_rnw),
    .rq_wdata  (rq_wdata),
    .rq_rdata  (rq_rdata),
    .de_req    (de_req),
    .de_ack    (de_ack),
    .de_addr   (de_addr),
    .de_nbyte  (de_nbyte),
    .de_rnw    (de_rnw),
    .de_w_data (de_w_data),
    .de_r_data (de_r_data),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rq_req    = 4'b0000;
    ack_en    = 1'b0;
    ack_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every new grant and every acknowledged beat is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (grant != prev_grant && grant != 4'b0000) begin
        if (exp_grant_q.size() == 0) begin
          chk("grant_unexpected", {60'd0, grant}, 64'd0);
        end else begin
          chk("grant_order", {60'd0, grant}, {60'd0, exp_grant_q.pop_front()});
        end
      end
      if (rq_ack != 4'b0000) begin
        if (exp_ack_q.size() == 0) begin
          chk("ack_unexpected", {60'd0, rq_ack}, 64'd0);
        end else begin
          int s;
          logic [3:0] oh;
          s  = exp_ack_q.pop_front();
          oh = 4'b0001 << s;
          chk("ack_slot",  {60'd0, rq_ack}, {60'd0, oh});
          chk("ack_owner", {60'd0, rq_ack}, {60'd0, grant});
          chk("ack_xfer", {de_addr, de_nbyte, de_rnw, 9'd0, de_w_data},
                          {addr_tab[s], nbyte_tab[s], rnw_tab[s], 9'd0, wdata_tab[s]});
          chk("ack_rdata", {32'd0, rq_rdata}, {32'd0, de_r_data});
        end
      end
    end
    prev_grant <= grant;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    prev_grant = 4'b0000;
    addr_tab[0] = 18'h00011; addr_tab[1] = 18'h00022;
    addr_tab[2] = 18'h000A5; addr_tab[3] = 18'h00133;
    nbyte_tab[0] = 4'h0; nbyte_tab[1] = 4'h3; nbyte_tab[2] = 4'hC; nbyte_tab[3] = 4'h6;
    rnw_tab[0] = 1'b1; rnw_tab[1] = 1'b0; rnw_tab[2] = 1'b1; rnw_tab[3] = 1'b0;
    wdata_tab[0] = 32'h0123_4567; wdata_tab[1] = 32'h1111_2222;
    wdata_tab[2] = 32'hA5A5_5A5A; wdata_tab[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      rq_addr[i*18 +: 18]  = addr_tab[i];
      rq_nbyte[i*4 +: 4]   = nbyte_tab[i];
      rq_rnw[i]            = rnw_tab[i];
      rq_wdata[i*32 +: 32] = wdata_tab[i];
    end
    de_r_data = 32'h5A5A_0F0F;
    rst       = 1'b1;
    rq_req    = 4'b0000;
    ack_en    = 1'b0;
    ack_force = 1'b0;

    // Reset release with no requests: stays idle for 10 cycles.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_idle", {58'd0, grant, de_req, busy}, 64'd0);
      next_cycle();
    end

    // Single requester on slot 2: 16 acks, one idle bubble, re-grant.
    de_r_data = 32'h0BAD_F00D;
    rq_req = 4'b0100;
    ack_en = 1'b1;
    exp_grant_q.push_back(4'b0100);
    for (int i = 0; i < 16; i++) exp_ack_q.push_back(2);
    exp_grant_q.push_back(4'b0100);
    @(negedge clk);
    chk("arb_latency_c0", {59'd0, grant, busy}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("first_grant", {41'd0, grant, de_req, de_addr}, {41'd0, 4'b0100, 1'b1, 18'h000A5});
    repeat (15) next_cycle();
    next_cycle();
    ack_en    = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    chk("idle_bubble", {58'd0, grant, de_req, busy}, 64'd0);
    chk("idle_ack_ignored", {60'd0, rq_ack}, 64'd0);
    next_cycle();
    ack_force = 1'b0;
    @(negedge clk);
    chk("regrant", {59'd0, grant, busy}, {59'd0, 4'b0100, 1'b1});
    next_cycle();
    rq_req = 4'b0000;
    next_cycle();

    // All four slots requesting continuously: order 0,1,2,3,0 with 16 acks each.
    do_reset();
    de_r_data = 32'h1357_9BDF;
    rq_req = 4'b1111;
    ack_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      exp_grant_q.push_back(4'b0001 << s);
      for (int i = 0; i < 16; i++) exp_ack_q.push_back(s);
    end
    exp_grant_q.push_back(4'b0001);
    repeat (68) next_cycle();
    ack_en = 1'b0;
    next_cycle();
    rq_req = 4'b0000;
    next_cycle();

    // Slot 1 drops after 3 acks while slot 3 waits.
    do_reset();
    rq_req = 4'b1010;
    ack_en = 1'b1;
    exp_grant_q.push_back(4'b0010);
    for (int i = 0; i < 3; i++) exp_ack_q.push_back(1);
    repeat (3) next_cycle();
    next_cycle();
    rq_req = 4'b1000;
    next_cycle();
    ack_en = 1'b0;
    exp_grant_q.push_back(4'b1000);
    @(negedge clk);
    chk("drop_idle", {59'd0, grant, busy}, 64'd0);
    chk("drop_rr_ptr", {62'd0, dut.rr_ptr_q}, 64'd2);
    next_cycle();
    @(negedge clk);
    chk("drop_regrant", {60'd0, grant}, {60'd0, 4'b1000});

    // No ack for 20 cycles: owner, beat and write data hold.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_hold", {22'd0, grant, de_req, de_w_data, dut.beat_q},
                        {22'd0, 4'b1000, 1'b1, 32'hDEAD_BEEF, 5'd0});
      next_cycle();
    end

    // Reset mid-burst at beat 7: outputs fall without a clock edge.
    ack_en = 1'b1;
    for (int i = 0; i < 7; i++) exp_ack_q.push_back(3);
    repeat (7) next_cycle();
    chk("beat_before_reset", {59'd0, dut.beat_q}, 64'd7);
    rst = 1'b1;
    #1;
    chk("async_reset", {55'd0, de_req, grant, rq_ack}, 64'd0);
    rq_req = 4'b0001;
    ack_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_grant_q.push_back(4'b0001);
    @(negedge clk);
    chk("post_reset_idle", {60'd0, grant}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("post_reset_grant", {59'd0, grant, busy}, {59'd0, 4'b0001, 1'b1});
    next_cycle();
    rq_req = 4'b0000;
    repeat (3) next_cycle();

    chk("grant_queue_empty", 64'(exp_grant_q.size()), 64'd0);
    chk("ack_queue_empty", 64'(exp_ack_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
